// File: rtl/wb_stage_ctrl_if.sv
// Bus bundle for the write-back stage: upstream retire handshake, late
// memory read data, register-file write port and forwarding/hazard status.
interface wb_stage_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] y_in;
  logic [REG_AW-1:0] wa_in;
  logic              werf_in;
  logic [1:0]        wdsel_in;
  logic              mrd_valid;
  logic [DATA_W-1:0] mrd;
  logic [REG_AW-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              werf;
  logic              fwd_busy;
  logic              fwd_data_ok;
  logic              stall_out;

  // Stage side.
  modport slave (
    input  valid_in, pc_in, y_in, wa_in, werf_in, wdsel_in, mrd_valid, mrd,
    output ready_out, wa, wd, werf, fwd_busy, fwd_data_ok, stall_out
  );

  // Memory-stage / register-file side.
  modport master (
    output valid_in, pc_in, y_in, wa_in, werf_in, wdsel_in, mrd_valid, mrd,
    input  ready_out, wa, wd, werf, fwd_busy, fwd_data_ok, stall_out
  );
endinterface

// File: rtl/wb_stage_ctrl.sv
// Registered write-back stage: holds one retiring instruction, waits for late
// load data, drives the register-file write. Macro WB_RETIRE_CNT_EN adds retired_cnt.
module wb_stage_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic          clk,
  input  logic          n_rst,
  wb_stage_ctrl_if.slave wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   retired_cnt
`endif
);

  localparam logic [1:0] WDSEL_PC  = 2'b00;
  localparam logic [1:0] WDSEL_Y   = 2'b01;
  localparam logic [1:0] WDSEL_MRD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] mrd;
    logic [REG_AW-1:0] wa;
    logic              werf;
    logic [1:0]        wdsel;
  } entry_t;

  state_t            state;
  entry_t            held;
  logic              accept;
  logic              is_load;
  logic              wr_live;
  logic [DATA_W-1:0] wd_mux;

  assign accept  = wb.valid_in && (state != WAIT);
  assign is_load = (wb.wdsel_in == WDSEL_MRD);
  assign wr_live = held.werf && (held.wa != REG_AW'(ZERO_REG));

  // FSM and held entry; an accept in COMMIT overwrites the entry being written.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      held  <= '0;
    end else begin
      case (state)
        IDLE, COMMIT: begin
          if (accept) begin
            held.pc    <= wb.pc_in;
            held.y     <= wb.y_in;
            held.mrd   <= wb.mrd;
            held.wa    <= wb.wa_in;
            held.werf  <= wb.werf_in;
            held.wdsel <= wb.wdsel_in;
            state      <= (is_load && !wb.mrd_valid) ? WAIT : COMMIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wb.mrd_valid) begin
            held.mrd <= wb.mrd;
            state    <= COMMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-data select; only meaningful while committing.
  always_comb begin
    wd_mux = '0;
    if (state == COMMIT) begin
      case (held.wdsel)
        WDSEL_PC:  wd_mux = held.pc;
        WDSEL_Y:   wd_mux = held.y;
        WDSEL_MRD: wd_mux = held.mrd;
        default:   wd_mux = '0;
      endcase
    end
  end

  assign wb.ready_out   = (state != WAIT);
  assign wb.stall_out   = (state == WAIT);
  assign wb.wa          = held.wa;
  assign wb.wd          = wd_mux;
  assign wb.werf        = (state == COMMIT) && wr_live;
  assign wb.fwd_data_ok = (state == COMMIT) && wr_live;
  assign wb.fwd_busy    = (state != IDLE) && wr_live;

`ifdef WB_RETIRE_CNT_EN
  // Counts COMMIT cycles, including suppressed writes to the zero register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      retired_cnt <= '0;
    end else if (state == COMMIT) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl: scoreboard of expected register-file
// writes plus per-scenario inline checks.
module tb_wb_stage_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } exp_t;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;
  int   exp_cnt;
  exp_t sb[$];
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  wb_stage_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_stage_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(31)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .wb    (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.werf === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got wa=%0d wd=%h, expected no write", bus.wa, bus.wd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.wa !== e.wa || bus.wd !== e.wd || bus.fwd_data_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_write: got wa=%0d wd=%h fwd_ok=%b, expected wa=%0d wd=%h fwd_ok=1",
                   bus.wa, bus.wd, bus.fwd_data_ok, e.wa, e.wd);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid_in  = 1'b0;
    bus.pc_in     = '0;
    bus.y_in      = '0;
    bus.wa_in     = '0;
    bus.werf_in   = 1'b0;
    bus.wdsel_in  = 2'b00;
    bus.mrd_valid = 1'b0;
    bus.mrd       = '0;
  endtask

  task automatic drive_instr(input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] y,
                             input logic [4:0] wa, input logic we);
    bus.valid_in = 1'b1;
    bus.wdsel_in = sel;
    bus.pc_in    = pc;
    bus.y_in     = y;
    bus.wa_in    = wa;
    bus.werf_in  = we;
  endtask

  task automatic test_reset();
    drive_idle();
    n_rst = 1'b0;
    #12;
    n_checks++;
    if (bus.ready_out !== 1'b1 || bus.stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got ready=%b stall=%b, expected ready=1 stall=0", bus.ready_out, bus.stall_out);
    end
    n_checks++;
    if (bus.werf !== 1'b0 || bus.wd !== 32'h0 || bus.wa !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_write_port: got werf=%b wa=%0d wd=%h, expected 0/0/0", bus.werf, bus.wa, bus.wd);
    end
    n_checks++;
    if (bus.fwd_busy !== 1'b0 || bus.fwd_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fwd: got busy=%b ok=%b, expected 0/0", bus.fwd_busy, bus.fwd_data_ok);
    end
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retired_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h expected 0", retired_cnt);
    end
`endif
    @(negedge clk);
    n_rst   = 1'b1;
    exp_cnt = 0;
    step();
  endtask

  task automatic test_alu();
    drive_instr(2'b01, 32'h100, 32'h1234, 5'd3, 1'b1);
    sb.push_back('{wa: 5'd3, wd: 32'h1234});
    step();
    drive_idle();
    exp_cnt++;
    n_checks++;
    if (bus.werf !== 1'b1 || bus.fwd_busy !== 1'b1 || bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_commit: got werf=%b busy=%b ready=%b, expected 1/1/1", bus.werf, bus.fwd_busy, bus.ready_out);
    end
    step();
    n_checks++;
    if (bus.werf !== 1'b0 || bus.fwd_busy !== 1'b0 || bus.wd !== 32'h0) begin
      n_fail++;
      $display("FAIL alu_after: got werf=%b busy=%b wd=%h, expected 0/0/0", bus.werf, bus.fwd_busy, bus.wd);
    end
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retired_cnt !== 32'(exp_cnt)) begin
      n_fail++;
      $display("FAIL alu_cnt: got %0d expected %0d", retired_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_load_late();
    drive_instr(2'b10, 32'h200, 32'h0BAD, 5'd5, 1'b1);
    bus.mrd = 32'h5555_5555;
    step();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.stall_out !== 1'b1 || bus.ready_out !== 1'b0 || bus.fwd_busy !== 1'b1 || bus.werf !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait[%0d]: got stall=%b ready=%b busy=%b werf=%b, expected 1/0/1/0",
                 i, bus.stall_out, bus.ready_out, bus.fwd_busy, bus.werf);
      end
      if (i == 2) begin
        bus.mrd_valid = 1'b1;
        bus.mrd       = 32'hDEADBEEF;
        sb.push_back('{wa: 5'd5, wd: 32'hDEADBEEF});
      end
      step();
    end
    drive_idle();
    exp_cnt++;
    n_checks++;
    if (bus.werf !== 1'b1 || bus.stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL load_commit: got werf=%b stall=%b, expected 1/0", bus.werf, bus.stall_out);
    end
    step();
    n_checks++;
    if (bus.werf !== 1'b0) begin
      n_fail++;
      $display("FAIL load_single_pulse: got werf=%b expected 0", bus.werf);
    end
  endtask

  task automatic test_load_fast_and_zero_sel();
    drive_instr(2'b10, 32'h300, 32'h1, 5'd7, 1'b1);
    bus.mrd_valid = 1'b1;
    bus.mrd       = 32'hCAFEF00D;
    sb.push_back('{wa: 5'd7, wd: 32'hCAFEF00D});
    step();
    drive_instr(2'b11, 32'h304, 32'h99, 5'd9, 1'b1);
    sb.push_back('{wa: 5'd9, wd: 32'h0});
    exp_cnt++;
    n_checks++;
    if (bus.werf !== 1'b1 || bus.stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fast: got werf=%b stall=%b, expected 1/0", bus.werf, bus.stall_out);
    end
    step();
    drive_idle();
    exp_cnt++;
    // Stray memory data while idle must be ignored.
    step();
    bus.mrd_valid = 1'b1;
    bus.mrd       = 32'h1111_2222;
    step();
    bus.mrd_valid = 1'b0;
    n_checks++;
    if (bus.werf !== 1'b0 || bus.stall_out !== 1'b0 || bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_mrd: got werf=%b stall=%b ready=%b, expected 0/0/1", bus.werf, bus.stall_out, bus.ready_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_instr(2'b00, 32'(4 * (i + 1)), 32'hFFFF, 5'(i + 10), 1'b1);
      sb.push_back('{wa: 5'(i + 10), wd: 32'(4 * (i + 1))});
      step();
      exp_cnt++;
      n_checks++;
      if (bus.werf !== 1'b1 || bus.wd !== 32'(4 * (i + 1))) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got werf=%b wd=%h, expected 1/%h", i, bus.werf, bus.wd, 32'(4 * (i + 1)));
      end
    end
    drive_idle();
    step();
    n_checks++;
    if (bus.werf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got werf=%b expected 0", bus.werf);
    end
  endtask

  task automatic test_zero_reg();
    drive_instr(2'b01, 32'h400, 32'h7777, 5'd31, 1'b1);
    step();
    drive_idle();
    exp_cnt++;
    n_checks++;
    if (bus.werf !== 1'b0 || bus.fwd_busy !== 1'b0 || bus.fwd_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg: got werf=%b busy=%b ok=%b, expected 0/0/0", bus.werf, bus.fwd_busy, bus.fwd_data_ok);
    end
    step();
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retired_cnt !== 32'(exp_cnt)) begin
      n_fail++;
      $display("FAIL zero_reg_cnt: got %0d expected %0d", retired_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    drive_instr(2'b10, 32'h500, 32'h0, 5'd4, 1'b1);
    step();
    drive_idle();
    n_checks++;
    if (bus.stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_entry: got stall=%b expected 1", bus.stall_out);
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (bus.ready_out !== 1'b1 || bus.stall_out !== 1'b0 || bus.fwd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_clear: got ready=%b stall=%b busy=%b, expected 1/0/0", bus.ready_out, bus.stall_out, bus.fwd_busy);
    end
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retired_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_wait_cnt: got %h expected 0", retired_cnt);
    end
`endif
    exp_cnt = 0;
    @(negedge clk);
    n_rst = 1'b1;
    bus.mrd_valid = 1'b1;
    bus.mrd       = 32'hBADC0DE0;
    step();
    bus.mrd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.werf !== 1'b0 || bus.ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_wait_drop[%0d]: got werf=%b ready=%b, expected 0/1", i, bus.werf, bus.ready_out);
      end
      step();
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_cnt_wrap();
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    drive_instr(2'b01, 32'h600, 32'h42, 5'd2, 1'b1);
    sb.push_back('{wa: 5'd2, wd: 32'h42});
    step();
    drive_idle();
    n_checks++;
    if (retired_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL cnt_preload: got %h expected ffffffff", retired_cnt);
    end
    step();
    n_checks++;
    if (retired_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h expected 0", retired_cnt);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    test_reset();
    test_alu();
    test_load_late();
    test_load_fast_and_zero_sel();
    test_back_to_back();
    test_zero_reg();
    test_reset_in_wait();
`ifdef WB_RETIRE_CNT_EN
    test_cnt_wrap();
`endif
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending writes, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_stage_ctrl.md
# wb_stage_ctrl

Parametrised, registered write-back stage for the pipelined CPU. It accepts one retiring instruction per cycle from the memory stage, selects the register-file write data (PC+4, ALU result or memory read data), and waits for late memory read data with a valid handshake. It drives the register-file write port and a forwarding/hazard port for the earlier stages.

## Interface

**Parameters**
- `DATA_W`, 32, width of the datapath and register-file data.
- `REG_AW`, 5, register address width.
- `ZERO_REG`, 31, register index whose writes are suppressed (hard-wired zero).

**Ports**
- `clk`  in  1  clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  upstream has an instruction to retire.
- `ready_out`  out  1  this stage accepts this cycle.
- `pc_in`  in  DATA_W  PC+4 of the instruction.
- `y_in`  in  DATA_W  ALU result.
- `wa_in`  in  REG_AW  destination register (instruction field [25:21]).
- `werf_in`  in  1  instruction writes the register file.
- `wdsel_in`  in  2  write-data select: 00 PC, 01 Y, 10 MRD, 11 zero.
- `mrd_valid`  in  1  memory read data is valid this cycle.
- `mrd`  in  DATA_W  memory read data.
- `wa`  out  REG_AW  register-file write address.
- `wd`  out  DATA_W  register-file write data.
- `werf`  out  1  register-file write enable.
- `fwd_busy`  out  1  a pending write to `wa` is in flight.
- `fwd_data_ok`  out  1  `wd` is valid for forwarding.
- `stall_out`  out  1  stage is waiting on memory data.
- `retired_cnt`  out  32  retired-instruction count (only with `WB_RETIRE_CNT_EN`).

## Operation
- FSM states:
  - IDLE: empty.
  - WAIT: load accepted, no data yet.
  - COMMIT: write-data ready, write presented this cycle.
- Accept condition: `valid_in && ready_out`. Accept captures `pc_in`, `y_in`, `wa_in`, `werf_in` and `wdsel_in`.
- `ready_out` = (state != WAIT). Accepting in COMMIT replaces the held entry, giving back-to-back throughput.
- Transitions on accept:
  - `wdsel_in==10` with `mrd_valid` low: go to WAIT.
  - Otherwise go to COMMIT. If `wdsel_in==10` and `mrd_valid` is high in the accept cycle, `mrd` is captured.
- WAIT: on `mrd_valid`, capture `mrd` and go to COMMIT. Otherwise hold with no timeout.
- COMMIT with no accept: go to IDLE.
- `mrd_valid` outside WAIT or a load-accept cycle is ignored.
- `wd` is a mux of the held fields per the held `wdsel` (11 gives 0). It is meaningful only in COMMIT and is 0 otherwise.
- `werf` = COMMIT && held werf && (held wa != ZERO_REG).
- `fwd_busy` = (state != IDLE) && held werf && (held wa != ZERO_REG).
- `fwd_data_ok` = `werf`.
- `stall_out` = (state == WAIT).

## Timing
- Reset values: state IDLE; all held fields 0. Outputs: `ready_out`=1, `werf`=0, `wd`=0, `wa`=0, `fwd_*`=0, `stall_out`=0, `retired_cnt`=0.
- Non-load: accepted at edge N; `werf`/`wd` valid in the cycle after N (latency 1).
- Load with data in the accept cycle: latency 1.
- Load with data k cycles later: `werf` in the cycle after the `mrd_valid` edge. `ready_out` is low for the k cycles in between.
- Reset asserted in WAIT or COMMIT: returns to IDLE immediately. The pending write is dropped, no `werf` pulse, and the counter clears.
- Destination `ZERO_REG`: the entry still flows through the FSM and counts as retired, but `werf` stays 0.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - 32-bit `retired_cnt` increments by 1 on every cycle in COMMIT.
  - Wraps from 0xFFFFFFFF to 0.
- Not defined: the `retired_cnt` port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `valid_in=1`, `wdsel_in=01`, `y_in=0x1234`, `wa_in=3`, `werf_in=1` → next cycle `werf=1`, `wa=3`, `wd=0x1234`; following cycle `werf=0`.
- Load with `wdsel_in=10` and `mrd_valid` low for 3 cycles, then `mrd=0xDEADBEEF` → `stall_out=1` and `ready_out=0` for 3 cycles; then one `werf` pulse with `wd=0xDEADBEEF`.
- Back-to-back `wdsel_in=00` with `pc_in`=0x4, 0x8, 0xC on consecutive cycles → `wd`=0x4, 0x8, 0xC on consecutive cycles, `werf` continuously high.
- `wa_in=31`, `werf_in=1` → `werf` stays 0, `fwd_busy` stays 0, `retired_cnt` increments.
- `n_rst` pulsed low while in WAIT → no `werf` pulse; `ready_out`=1 and `retired_cnt`=0 after reset.
- With `WB_RETIRE_CNT_EN`: preload the counter to 0xFFFFFFFF via force, then commit one instruction → `retired_cnt`=0.
